// File: rtl/cpu_trace_streamer.sv
// Per-instruction CPU trace framer: snapshots pc/inst on a retire strobe, walks the
// register file through a debug read port and streams one framed word sequence.
module cpu_trace_streamer #(
    parameter int NREGS = 32,
    parameter int SEQ_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             trig,
    input  logic [31:0]      pc,
    input  logic [31:0]      inst,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             busy,
    output logic [SEQ_W-1:0] drop_cnt,
    output logic             dbg_state
);

    // Stream handshake: a word transfers on a rising clk_in edge where m_valid && m_ready;
    // m_data/m_last/m_valid are registered and never change while m_valid && !m_ready.

    localparam int NWORDS = NREGS + 3;
    localparam int IDX_W  = $clog2(NWORDS);

    typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [SEQ_W-1:0]   drop_q, drop_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [31:0]        m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;

    logic               hs;
    logic               last_hs;
    logic               accept;
    logic [SEQ_W-1:0]   seq_inc;
    logic [31:0]        next_word;

    function automatic logic [31:0] header(input logic [SEQ_W-1:0] s);
        return {8'hA5, 8'(NWORDS), 16'(s)};
    endfunction

    assign hs      = m_valid_q & m_ready;
    assign last_hs = hs & m_last_q;
    assign seq_inc = seq_q + SEQ_W'(1);
    assign accept  = trig & ((state_q == S_IDLE) | last_hs);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            seq_q     <= '0;
            drop_q    <= '0;
            pc_q      <= '0;
            inst_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            drop_q    <= drop_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (trig) state_d = S_STREAM;
            S_STREAM: if (last_hs && !trig) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Word idx+1 follows the word currently presented; registers start at word 3.
    always_comb begin
        next_word = rf_rdata;
        if (idx_q == IDX_W'(0)) next_word = pc_q;
        else if (idx_q == IDX_W'(1)) next_word = inst_q;
    end

    always_comb begin
        idx_d     = idx_q;
        seq_d     = seq_q;
        drop_d    = drop_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        if (state_q == S_STREAM && last_hs) begin
            seq_d     = seq_inc;
            idx_d     = '0;
            m_data_d  = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else if (state_q == S_STREAM && hs) begin
            idx_d    = idx_q + IDX_W'(1);
            m_data_d = next_word;
            m_last_d = (idx_q == IDX_W'(NWORDS - 2));
        end

        // A trigger on the closing handshake chains straight into the next frame.
        if (accept) begin
            pc_d      = pc;
            inst_d    = inst;
            idx_d     = '0;
            m_data_d  = header((state_q == S_IDLE) ? seq_q : seq_inc);
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
        end

        if (state_q == S_STREAM && trig && !last_hs && drop_q != '1) begin
            drop_d = drop_q + SEQ_W'(1);
        end
    end

    always_comb begin
        rf_raddr = '0;
        if (state_q == S_STREAM && idx_q >= IDX_W'(2)) begin
            rf_raddr = 5'(32'(idx_q) - 32'd2);
        end
        m_valid   = m_valid_q;
        m_data    = m_data_q;
        m_last    = m_last_q;
        busy      = m_valid_q;
        drop_cnt  = drop_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// Bench for cpu_trace_streamer: a 32-register/16-bit-seq instance and an 8-register/4-bit-seq
// instance, checked word by word against frames built from the frame-layout rules.
module tb_cpu_trace_streamer;

    logic        clk;
    logic        reset_n;
    logic        trig;
    logic        m_ready;
    logic [31:0] pc;
    logic [31:0] inst;
    int          sel;

    logic [31:0] rf_mem [32];

    logic [4:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        m_valid_a, m_valid_b, m_last_a, m_last_b, busy_a, busy_b, dbg_a, dbg_b;
    logic [31:0] m_data_a, m_data_b;
    logic [15:0] drop_a;
    logic [3:0]  drop_b;
    logic        trig_a, trig_b;

    logic        o_valid, o_last, o_busy, o_dbg;
    logic [31:0] o_data;
    logic [4:0]  o_raddr;
    logic [15:0] o_drop;

    logic [31:0] exp_q[$];
    int          exp_seq[2];
    int          exp_drop[2];
    int          nregs[2];
    int          seqmax[2];
    int          n_checks;
    int          n_fail;
    int          cyc;

    assign trig_a     = trig & (sel == 0);
    assign trig_b     = trig & (sel == 1);
    assign rf_rdata_a = rf_mem[rf_raddr_a];
    assign rf_rdata_b = rf_mem[rf_raddr_b];

    assign o_valid = (sel == 1) ? m_valid_b : m_valid_a;
    assign o_last  = (sel == 1) ? m_last_b  : m_last_a;
    assign o_busy  = (sel == 1) ? busy_b    : busy_a;
    assign o_dbg   = (sel == 1) ? dbg_b     : dbg_a;
    assign o_data  = (sel == 1) ? m_data_b  : m_data_a;
    assign o_raddr = (sel == 1) ? rf_raddr_b : rf_raddr_a;
    assign o_drop  = (sel == 1) ? 16'(drop_b) : drop_a;

    cpu_trace_streamer #(.NREGS(32), .SEQ_W(16)) u_dut (
        .clk_in(clk), .reset_n(reset_n), .trig(trig_a), .pc(pc), .inst(inst),
        .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a), .m_valid(m_valid_a), .m_ready(m_ready),
        .m_data(m_data_a), .m_last(m_last_a), .busy(busy_a), .drop_cnt(drop_a), .dbg_state(dbg_a)
    );

    cpu_trace_streamer #(.NREGS(8), .SEQ_W(4)) u_dut8 (
        .clk_in(clk), .reset_n(reset_n), .trig(trig_b), .pc(pc), .inst(inst),
        .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b), .m_valid(m_valid_b), .m_ready(m_ready),
        .m_data(m_data_b), .m_last(m_last_b), .busy(busy_b), .drop_cnt(drop_b), .dbg_state(dbg_b)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, pc, inst, then the register file as it stands now.
    task automatic push_frame(input logic [31:0] pc_v, input logic [31:0] inst_v);
        logic [31:0] h;
        h = {8'hA5, 8'(nregs[sel] + 3), 16'(exp_seq[sel] & seqmax[sel])};
        exp_q.push_back(h);
        exp_q.push_back(pc_v);
        exp_q.push_back(inst_v);
        for (int i = 0; i < nregs[sel]; i++) exp_q.push_back(rf_mem[i]);
    endtask

    task automatic start_frame(input logic [31:0] pc_v, input logic [31:0] inst_v);
        @(negedge clk);
        trig = 1'b1;
        pc   = pc_v;
        inst = inst_v;
        push_frame(pc_v, inst_v);
        @(negedge clk);
        trig = 1'b0;
        chk("latency_valid", o_valid, 1);
    endtask

    // mode: 0 ready high, 1 ready toggling (low first), 2 random ready.
    // inject: 1 stray trig on words 5/7/9, 2 stray trig on every non-final cycle.
    task automatic run_frame(input int mode, input int inject, input int chain,
                             input int stop_after, output int cycles);
        int  fw;
        int  words;
        bit  gap_chk;
        bit  done;
        logic [31:0] exp_ra;
        cycles = 0; fw = 0; words = 0; gap_chk = 0; done = 0;
        while (!done && cycles < 3000) begin
            trig = 1'b0;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cycles % 2) == 1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (gap_chk) begin
                chk("no_gap_valid", o_valid, 1);
                gap_chk = 0;
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", o_valid, 0);
                end else begin
                    chk("m_data", o_data, exp_q[0]);
                    chk("m_last", o_last, exp_q.size() == 1);
                    chk("busy", o_busy, 1);
                    exp_ra = (fw >= 2) ? 32'((fw - 2) % 32) : 32'd0;
                    chk("rf_raddr", 32'(o_raddr), exp_ra);
                    if (fw < nregs[sel] + 2 &&
                        ((inject == 1 && m_ready && (fw == 5 || fw == 7 || fw == 9)) || inject == 2)) begin
                        trig = 1'b1;
                        pc   = $urandom;
                        inst = $urandom;
                        if (exp_drop[sel] < seqmax[sel]) exp_drop[sel]++;
                    end
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        fw++;
                        words++;
                        if (exp_q.size() == 0) begin
                            exp_seq[sel]++;
                            fw = 0;
                            if (chain > 0) begin
                                chain--;
                                trig = 1'b1;
                                pc   = $urandom;
                                inst = $urandom;
                                push_frame(pc, inst);
                                gap_chk = 1;
                            end else begin
                                done = 1;
                            end
                        end
                        if (stop_after > 0 && words == stop_after) done = 1;
                    end
                end
            end
            cycles++;
            @(negedge clk);
        end
        trig = 1'b0;
        chk("frame_done_in_budget", 32'(done), 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_state"}, o_dbg, 0);
        chk({tag, "_drop"}, 32'(o_drop), 32'(exp_drop[sel]));
    endtask

    // Directed steps with randomized data
    initial begin
        n_checks = 0; n_fail = 0;
        nregs  = '{32, 8};
        seqmax = '{65535, 15};
        exp_seq = '{0, 0};
        exp_drop = '{0, 0};
        sel = 0; trig = 1'b0; m_ready = 1'b0; pc = '0; inst = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i * 32'h11);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk_idle("reset");
            chk("reset_last", o_last, 0);
            chk("reset_data", o_data, 0);
            chk("reset_raddr", 32'(o_raddr), 0);
        end
        sel = 0;
        reset_n = 1'b1;
        @(negedge clk);

        start_frame(32'h0040_0000, 32'h3C01_0001);
        run_frame(0, 0, 0, 0, cyc);
        chk("full_rate_cycles", cyc, 35);
        chk_idle("after_frame0");

        start_frame(32'h0040_0000, 32'h3C01_0001);
        run_frame(1, 0, 0, 0, cyc);
        chk("toggle_cycles", cyc, 70);
        chk_idle("after_toggle");

        start_frame($urandom, $urandom);
        run_frame(0, 0, 2, 0, cyc);
        chk("chain3_cycles", cyc, 105);
        chk_idle("after_chain");

        start_frame($urandom, $urandom);
        run_frame(0, 1, 0, 0, cyc);
        chk("drop_cnt_3", 32'(o_drop), 3);
        chk_idle("after_drops");

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
            start_frame($urandom, $urandom);
            run_frame(2, 0, 0, 0, cyc);
            chk_idle("after_random");
        end

        sel = 1;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i * 32'h11);
        start_frame(32'h0040_0000, 32'h3C01_0001);
        chk("small_header", o_data, 32'hA50B_0000);
        run_frame(0, 0, 0, 0, cyc);
        chk("small_cycles", cyc, 11);
        chk_idle("small_after");

        start_frame($urandom, $urandom);
        run_frame(2, 0, 16, 0, cyc);
        chk("small_seq_model", 32'(exp_seq[1]), 18);
        chk_idle("small_after_wrap");

        start_frame($urandom, $urandom);
        run_frame(1, 2, 0, 0, cyc);
        chk("small_drop_sat", 32'(o_drop), 15);
        start_frame($urandom, $urandom);
        run_frame(0, 1, 0, 0, cyc);
        chk("small_drop_hold", 32'(o_drop), 15);
        chk_idle("small_after_sat");

        sel = 0;
        start_frame($urandom, $urandom);
        run_frame(0, 0, 0, 10, cyc);
        chk("mid_frame_valid", o_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_last", o_last, 0);
        chk("async_rst_data", o_data, 0);
        chk("async_rst_raddr", 32'(o_raddr), 0);
        chk("async_rst_busy", o_busy, 0);
        exp_q.delete();
        exp_seq = '{0, 0};
        exp_drop = '{0, 0};
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_idle("post_reset");
        start_frame(32'h1234_5678, 32'h8FBF_0014);
        chk("post_reset_header", o_data, 32'hA523_0000);
        run_frame(0, 0, 0, 0, cyc);
        chk_idle("post_reset_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
